// File: rtl/apb_master.sv
// apb_master: single-outstanding APB requester.
// Accepts one command on a valid/ready handshake, runs an APB SETUP/ACCESS
// transfer, and presents the result on a valid/ready response port.
//
// Parameters
//   ADDR_W  : APB address width
//   DATA_W  : APB data width
//   TIMEOUT : max ACCESS cycles before a forced error (0 disables, max 255)
//
// Ports
//   pclk, presetn                 : clock, async active-low reset
//   cmd_valid/cmd_ready           : command handshake
//   cmd_write/cmd_addr/cmd_wdata  : command payload
//   rsp_valid/rsp_ready           : response handshake
//   rsp_rdata/rsp_err             : response payload
//   psel/penable/pwrite/paddr/pwdata : APB request
//   prdata/pready/pslverr         : APB completer response
module apb_master #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_RESP
  } state_e;

  // Counter compare value; only meaningful when TIMEOUT != 0.
  localparam logic [7:0] TLIMIT = 8'(TIMEOUT - 1);

  state_e              state_q;
  logic [7:0]          tcnt_q;
  logic                pwrite_q;
  logic [ADDR_W-1:0]   paddr_q;
  logic [DATA_W-1:0]   pwdata_q;
  logic [DATA_W-1:0]   rsp_rdata_q;
  logic                rsp_err_q;
  logic                timeout_hit;

  assign timeout_hit = (TIMEOUT != 0) && (tcnt_q == TLIMIT);

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q     <= S_IDLE;
      tcnt_q      <= '0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            pwrite_q <= cmd_write;
            paddr_q  <= cmd_addr;
            pwdata_q <= cmd_wdata;
            tcnt_q   <= '0;
            state_q  <= S_SETUP;
          end
        end
        S_SETUP: begin
          state_q <= S_ACCESS;
        end
        S_ACCESS: begin
          // pready wins over a timeout expiring in the same cycle.
          if (pready) begin
            rsp_rdata_q <= pwrite_q ? '0 : prdata;
            rsp_err_q   <= pslverr;
            state_q     <= S_RESP;
          end else if (timeout_hit) begin
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b1;
            state_q     <= S_RESP;
          end else begin
            tcnt_q <= tcnt_q + 8'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Control strobes decoded straight from the registered state.
  assign cmd_ready = (state_q == S_IDLE);
  assign psel      = (state_q == S_SETUP) || (state_q == S_ACCESS);
  assign penable   = (state_q == S_ACCESS);
  assign rsp_valid = (state_q == S_RESP);
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master.sv
// Testbench for apb_master (TIMEOUT=4): table of directed transfers plus
// hand-written sequences for response back-pressure and mid-transfer reset.
module tb_apb_master;

  logic        pclk = 1'b0;
  logic        presetn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata, prdata;
  logic        pready, pslverr;

  int n_pass = 0;
  int n_total = 0;

  apb_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .pclk      (pclk),
    .presetn   (presetn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .prdata    (prdata),
    .pready    (pready),
    .pslverr   (pslverr)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] prdata;
    int          wait_cyc;   // ACCESS cycles with pready=0 before pready=1
    logic        slverr;
    int          exp_acc;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Issue a command and run it until the response is presented.
  task automatic do_xfer(input vec_t v);
    int n;
    @(negedge pclk);
    cmd_valid = 1'b1; cmd_write = v.wr; cmd_addr = v.addr; cmd_wdata = v.wdata;
    chk("idle_cmd_ready", cmd_ready, 1);
    @(negedge pclk);
    cmd_valid = 1'b0; cmd_addr = ~v.addr; cmd_wdata = ~v.wdata; cmd_write = ~v.wr;
    chk("setup_psel_penable", {psel, penable}, 2'b10);
    chk("setup_paddr", paddr, v.addr);
    chk("setup_pwrite", pwrite, v.wr);
    chk("setup_pwdata", pwdata, v.wdata);
    chk("setup_cmd_ready", cmd_ready, 0);
    @(negedge pclk);
    n = 0;
    while (psel && penable && n < 40) begin
      prdata  = v.prdata;
      pslverr = v.slverr;
      pready  = (n >= v.wait_cyc);
      @(negedge pclk);
      n++;
    end
    pready = 1'b0; pslverr = 1'b0; prdata = 32'h0;
    chk("access_cycles", n, v.exp_acc);
    chk("resp_valid", rsp_valid, 1);
    chk("resp_psel_penable", {psel, penable}, 2'b00);
    chk("resp_err", rsp_err, v.exp_err);
    chk("resp_rdata", rsp_rdata, v.exp_rdata);
    chk("resp_cmd_ready", cmd_ready, 0);
  endtask

  task automatic drain(input logic [31:0] addr);
    rsp_ready = 1'b1;
    @(negedge pclk);
    rsp_ready = 1'b0;
    chk("post_cmd_ready", cmd_ready, 1);
    chk("post_rsp_valid", rsp_valid, 0);
    chk("post_paddr_held", paddr, addr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    //          wr    addr       wdata         prdata        wait slv  acc err  rdata
    vecs[0] = '{1'b1, 32'h10, 32'hA5A5A5A5, 32'hFFFF0000, 0,   1'b0, 1, 1'b0, 32'h0};
    vecs[1] = '{1'b0, 32'h20, 32'h0,        32'h12345678, 3,   1'b0, 4, 1'b0, 32'h12345678};
    vecs[2] = '{1'b0, 32'h30, 32'h0,        32'hDEADBEEF, 1,   1'b1, 2, 1'b1, 32'hDEADBEEF};
    vecs[3] = '{1'b0, 32'h40, 32'h0,        32'h55555555, 255, 1'b0, 4, 1'b1, 32'h0};
    vecs[4] = '{1'b0, 32'h44, 32'h0,        32'hCAFEF00D, 3,   1'b0, 4, 1'b0, 32'hCAFEF00D};
    vecs[5] = '{1'b1, 32'h50, 32'h11112222, 32'h77777777, 0,   1'b1, 1, 1'b1, 32'h0};
    vecs[6] = '{1'b1, 32'h60, 32'h33334444, 32'h88888888, 255, 1'b0, 4, 1'b1, 32'h0};

    presetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; prdata = '0; pready = 1'b0; pslverr = 1'b0;
    @(negedge pclk); @(negedge pclk);
    chk("rst_outputs", {psel, penable, pwrite, rsp_valid, rsp_err}, 5'b0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwdata", pwdata, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    presetn = 1'b1;
    @(negedge pclk);
    chk("rst_cmd_ready", cmd_ready, 1);

    for (int i = 0; i < 7; i++) begin
      do_xfer(vecs[i]);
      drain(vecs[i].addr);
    end

    // Response back-pressure while a new command waits.
    do_xfer(vecs[1]);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h80; cmd_wdata = 32'h0BADF00D;
    for (int k = 0; k < 5; k++) begin
      chk("bp_cmd_ready", cmd_ready, 0);
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_rdata", rsp_rdata, 32'h12345678);
      chk("bp_psel", psel, 0);
      @(negedge pclk);
    end
    rsp_ready = 1'b1;
    @(negedge pclk);
    rsp_ready = 1'b0;
    chk("bp_idle_cmd_ready", cmd_ready, 1);
    @(negedge pclk);
    cmd_valid = 1'b0;
    chk("bp_new_setup", {psel, penable, pwrite}, 3'b101);
    chk("bp_new_paddr", paddr, 32'h80);
    chk("bp_new_pwdata", pwdata, 32'h0BADF00D);
    pready = 1'b1;
    @(negedge pclk);
    @(negedge pclk);
    pready = 1'b0;
    chk("bp_new_resp", {rsp_valid, rsp_err}, 2'b10);
    chk("bp_new_rdata", rsp_rdata, 0);
    drain(32'h80);

    // Reset asserted in the middle of an ACCESS phase.
    @(negedge pclk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h90;
    @(negedge pclk);
    cmd_valid = 1'b0;
    @(negedge pclk);
    chk("mid_access", {psel, penable}, 2'b11);
    #2 presetn = 1'b0;
    #1;
    chk("mid_rst_psel_penable", {psel, penable}, 2'b00);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_paddr", paddr, 0);
    @(negedge pclk);
    presetn = 1'b1;
    @(negedge pclk);
    chk("mid_rst_cmd_ready", cmd_ready, 1);
    chk("mid_rst_no_resp", {rsp_valid, psel}, 2'b00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning APB address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning APB data width.
REQ-003 The block SHALL have parameter TIMEOUT, default 16, range 0..255, meaning the maximum number of ACCESS cycles before forced error; 0 disables the timeout.
REQ-004 pclk  input  1  single clock; all state updates on the rising edge.
REQ-005 presetn  input  1  reset, asynchronous and active-low.
REQ-006 cmd_valid  input  1  command request.
REQ-007 cmd_ready  output  1  block can accept a command.
REQ-008 cmd_write  input  1  1 = write, 0 = read.
REQ-009 cmd_addr  input  ADDR_W  transfer address.
REQ-010 cmd_wdata  input  DATA_W  write data.
REQ-011 rsp_valid  output  1  response available.
REQ-012 rsp_ready  input  1  response consumed.
REQ-013 rsp_rdata  output  DATA_W  read data; 0 for writes and timeouts.
REQ-014 rsp_err  output  1  pslverr or timeout occurred.
REQ-015 psel, penable, pwrite  output  1 each  APB control.
REQ-016 paddr  output  ADDR_W; pwdata  output  DATA_W  APB address and write data.
REQ-017 prdata  input  DATA_W; pready, pslverr  input  1 each  APB completer response.

Function
REQ-018 The block SHALL implement the four states IDLE, SETUP, ACCESS and RESP, with a single transfer outstanding.
REQ-019 IDLE: cmd_ready=1; when cmd_valid=1, the block SHALL capture cmd_write, cmd_addr and cmd_wdata and go to SETUP.
REQ-020 SETUP: psel=1 and penable=0 for exactly one cycle, then the block SHALL go to ACCESS unconditionally.
REQ-021 ACCESS: psel=1 and penable=1; the block SHALL hold state while pready=0.
REQ-022 ACCESS with pready=1: the block SHALL register rsp_rdata=prdata (reads) or 0 (writes) and rsp_err=pslverr, then go to RESP.
REQ-023 Timeout: a counter SHALL clear on SETUP entry and increment on each ACCESS cycle with pready=0.
REQ-024 When the counter reaches TIMEOUT-1 with pready still 0 (TIMEOUT>0), the block SHALL set rsp_err=1 and rsp_rdata=0, deassert psel/penable, and go to RESP.
REQ-025 pready=1 in the same cycle as timeout expiry SHALL take priority and complete normally.
REQ-026 RESP: rsp_valid=1, psel=0, penable=0; rsp_rdata/rsp_err SHALL remain stable until rsp_ready=1, then the block SHALL go to IDLE.
REQ-027 cmd_ready SHALL be 0 in SETUP, ACCESS and RESP; cmd_valid there SHALL be ignored.
REQ-028 paddr, pwrite and pwdata SHALL hold captured values from SETUP through the end of ACCESS and remain unchanged until the next capture.
REQ-029 psel and penable SHALL be decoded from state (glitch-free registered state); penable SHALL never be 1 without psel.
REQ-030 Latency: with pready=1 on the first ACCESS cycle and rsp_ready=1, command acceptance at cycle N SHALL give SETUP at N+1, ACCESS at N+2, rsp_valid at N+3, and IDLE at N+4.

Reset
REQ-031 When presetn=0, the block SHALL go to IDLE immediately and clear psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err and the timeout counter to 0.
REQ-032 After presetn=1, cmd_ready SHALL be 1.
REQ-033 Reset asserted mid-transfer SHALL abort the transfer and discard any pending response.

Verification
REQ-034 Write cmd addr=0x10, wdata=0xA5A5A5A5, with pready tied 1 -> SETUP one cycle then ACCESS one cycle with paddr=0x10, pwrite=1, pwdata=0xA5A5A5A5; rsp_valid with rsp_err=0, rsp_rdata=0.
REQ-035 Read addr=0x20, prdata=0x12345678, pready low for 3 ACCESS cycles -> penable high for 4 cycles; rsp_rdata=0x12345678, rsp_err=0.
REQ-036 Read with pslverr=1 at completion -> rsp_err=1, rsp_rdata=prdata.
REQ-037 TIMEOUT=4, pready held 0 -> exactly 4 ACCESS cycles, then psel=0 and rsp_err=1, rsp_rdata=0; pready=1 on the 4th cycle -> normal completion instead.
REQ-038 rsp_ready held 0 for 5 cycles, then a new cmd_valid -> cmd_ready stays 0 and response stays stable; after rsp_ready the new command is accepted.
REQ-039 presetn pulsed low during ACCESS -> psel/penable/rsp_valid=0 asynchronously; cmd_ready=1 after release.
